// File: rtl/ccd_line_sequencer_pkg.sv
// Shared types and default timing for the CCD line sequencer.
package ccd_line_sequencer_pkg;

    typedef enum logic [1:0] {IDLE, SH_PULSE, READOUT, WAIT_INT} ccd_seq_state_t;

    localparam int PIX_COUNT_DEF = 2160;
    localparam int DUMMY_PIX_DEF = 32;
    localparam int PIX_DIV_DEF   = 50;
    localparam int RS_W_DEF      = 4;
    localparam int CP_W_DEF      = 4;
    localparam int SAMPLE_PT_DEF = 12;
    localparam int SH_W_DEF      = 200;
    localparam int SH_GAP_DEF    = 100;
    localparam int INT_W_DEF     = 24;

    localparam int ADC_W     = 16;
    localparam int PIX_IDX_W = 12;

endpackage

// File: rtl/ccd_line_sequencer_if.sv
// ADC request/response and pixel-stream signals between the sequencer and its neighbours.
interface ccd_line_sequencer_if;
    import ccd_line_sequencer_pkg::*;

    logic                 adc_start;
    logic                 adc_done;
    logic [ADC_W-1:0]     adc_data;
    logic                 pix_valid;
    logic                 pix_ready;
    logic [ADC_W-1:0]     pix_data;
    logic [PIX_IDX_W-1:0] pix_index;
    logic                 pix_last;

    modport master (
        output adc_start, pix_valid, pix_data, pix_index, pix_last,
        input  adc_done, adc_data, pix_ready
    );

    modport slave (
        input  adc_start, pix_valid, pix_data, pix_index, pix_last,
        output adc_done, adc_data, pix_ready
    );

endinterface

// File: rtl/ccd_pixel_timer.sv
// Pixel-period counter with P1/P2/RS/CP/sample decode; decode is forced low while disabled.
module ccd_pixel_timer #(
    parameter int PIX_DIV   = ccd_line_sequencer_pkg::PIX_DIV_DEF,
    parameter int RS_W      = ccd_line_sequencer_pkg::RS_W_DEF,
    parameter int CP_W      = ccd_line_sequencer_pkg::CP_W_DEF,
    parameter int SAMPLE_PT = ccd_line_sequencer_pkg::SAMPLE_PT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic restart,
    output logic p1,
    output logic p2,
    output logic rs,
    output logic cp,
    output logic adc_start,
    output logic period_end
);

    localparam int PC_W = $clog2(PIX_DIV);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(PIX_DIV - 1);
    localparam logic [PC_W-1:0] PC_HALF = PC_W'(PIX_DIV / 2);
    localparam logic [PC_W-1:0] PC_RS   = PC_W'(RS_W);
    localparam logic [PC_W-1:0] PC_CP   = PC_W'(RS_W + CP_W);
    localparam logic [PC_W-1:0] PC_SMP  = PC_W'(SAMPLE_PT);

    logic [PC_W-1:0] pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pc <= '0;
        else if (restart)
            pc <= '0;
        else if (enable)
            pc <= (pc == PC_LAST) ? '0 : pc + PC_W'(1);
    end

    always_comb begin
        p1         = enable && (pc <  PC_HALF);
        p2         = enable && (pc >= PC_HALF);
        rs         = enable && (pc <  PC_RS);
        cp         = enable && (pc >= PC_RS) && (pc < PC_CP);
        adc_start  = enable && (pc == PC_SMP);
        period_end = enable && (pc == PC_LAST);
    end

endmodule

// File: rtl/ccd_line_sequencer.sv
// CCD line capture sequencer: SH transfer, per-pixel clocking, ADC requests and
// a single-entry indexed pixel output with sticky overrun/missed-conversion flags.
module ccd_line_sequencer
    import ccd_line_sequencer_pkg::*;
#(
    parameter int PIX_COUNT = PIX_COUNT_DEF,
    parameter int DUMMY_PIX = DUMMY_PIX_DEF,
    parameter int PIX_DIV   = PIX_DIV_DEF,
    parameter int RS_W      = RS_W_DEF,
    parameter int CP_W      = CP_W_DEF,
    parameter int SAMPLE_PT = SAMPLE_PT_DEF,
    parameter int SH_W      = SH_W_DEF,
    parameter int SH_GAP    = SH_GAP_DEF,
    parameter int INT_W     = INT_W_DEF
) (
    input  logic             clk_100M,
    input  logic             rst,
    input  logic             run,
    input  logic [INT_W-1:0] int_cycles,
    input  logic             err_clr,
    output logic             busy,
    output logic             line_done,
    output logic             ccd_p1,
    output logic             ccd_p2,
    output logic             ccd_sh,
    output logic             ccd_rs,
    output logic             ccd_cp,
    output logic             err_overrun,
    output logic             err_missed,
    ccd_line_sequencer_if.master link
);

    localparam int NPIX = DUMMY_PIX + PIX_COUNT;
    localparam int PX_W = $clog2(NPIX);
    localparam int PH_W = $clog2(SH_W + SH_GAP);
    localparam logic [PX_W-1:0] PX_LAST   = PX_W'(NPIX - 1);
    localparam logic [PX_W-1:0] PX_DUMMY  = PX_W'(DUMMY_PIX);
    localparam logic [PH_W-1:0] PH_SH_END = PH_W'(SH_W);
    localparam logic [PH_W-1:0] PH_LAST   = PH_W'(SH_W + SH_GAP - 1);

    ccd_seq_state_t   state;
    logic [PH_W-1:0]  ph_cnt;
    logic [PX_W-1:0]  px;
    logic [INT_W-1:0] line_tmr;
    logic [INT_W-1:0] int_lat;
    logic [INT_W:0]   tmr_inc;

    logic t_p1, t_p2, t_rs, t_cp, t_start, period_end;
    logic in_readout, last_px;
    logic outst, cap, new_pix, missed;

    assign in_readout = (state == READOUT);
    assign busy       = (state != IDLE);
    assign last_px    = (px == PX_LAST);
    // line timer counts the current cycle too, so a period of N re-enters SH exactly N cycles later
    assign tmr_inc    = {1'b0, line_tmr} + (INT_W+1)'(1);

    ccd_pixel_timer #(
        .PIX_DIV   (PIX_DIV),
        .RS_W      (RS_W),
        .CP_W      (CP_W),
        .SAMPLE_PT (SAMPLE_PT)
    ) u_timer (
        .clk        (clk_100M),
        .rst        (rst),
        .enable     (in_readout),
        .restart    (!in_readout),
        .p1         (t_p1),
        .p2         (t_p2),
        .rs         (t_rs),
        .cp         (t_cp),
        .adc_start  (t_start),
        .period_end (period_end)
    );

    always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            ph_cnt         <= '0;
            px             <= '0;
            line_tmr       <= '0;
            int_lat        <= '0;
            line_done      <= 1'b0;
            ccd_p1         <= 1'b0;
            ccd_p2         <= 1'b0;
            ccd_sh         <= 1'b0;
            ccd_rs         <= 1'b0;
            ccd_cp         <= 1'b0;
            link.adc_start <= 1'b0;
        end else begin
            line_done <= 1'b0;
            if (line_tmr != '1)
                line_tmr <= line_tmr + INT_W'(1);

            case (state)
                IDLE: begin
                    if (run) begin
                        state    <= SH_PULSE;
                        ph_cnt   <= '0;
                        int_lat  <= int_cycles;
                        line_tmr <= '0;
                    end
                end
                SH_PULSE: begin
                    if (ph_cnt == PH_LAST) begin
                        state  <= READOUT;
                        ph_cnt <= '0;
                    end else begin
                        ph_cnt <= ph_cnt + PH_W'(1);
                    end
                end
                READOUT: begin
                    if (period_end) begin
                        if (last_px) begin
                            px        <= '0;
                            line_done <= 1'b1;
                            state     <= run ? WAIT_INT : IDLE;
                        end else begin
                            px <= px + PX_W'(1);
                        end
                    end
                end
                WAIT_INT: begin
                    if (!run) begin
                        state <= IDLE;
                    end else if (tmr_inc >= {1'b0, int_lat}) begin
                        state    <= SH_PULSE;
                        ph_cnt   <= '0;
                        int_lat  <= int_cycles;
                        line_tmr <= '0;
                    end
                end
                default: state <= IDLE;
            endcase

            ccd_sh         <= (state == SH_PULSE) && (ph_cnt < PH_SH_END);
            ccd_p1         <= (state == SH_PULSE) || (state == WAIT_INT) || t_p1;
            ccd_p2         <= t_p2;
            ccd_rs         <= t_rs;
            ccd_cp         <= t_cp;
            link.adc_start <= t_start;
        end
    end

    // adc_done only counts while a request is outstanding; the period end abandons it
    assign cap     = outst && link.adc_done;
    assign new_pix = cap && (px >= PX_DUMMY);
    assign missed  = outst && !link.adc_done && period_end;

    always_ff @(posedge clk_100M or posedge rst) begin
        if (rst) begin
            outst          <= 1'b0;
            link.pix_valid <= 1'b0;
            link.pix_data  <= '0;
            link.pix_index <= '0;
            link.pix_last  <= 1'b0;
            err_overrun    <= 1'b0;
            err_missed     <= 1'b0;
        end else begin
            if (t_start)
                outst <= 1'b1;
            else if (cap || period_end)
                outst <= 1'b0;

            if (link.pix_valid && link.pix_ready)
                link.pix_valid <= 1'b0;
            if (new_pix && (!link.pix_valid || link.pix_ready)) begin
                link.pix_valid <= 1'b1;
                link.pix_data  <= link.adc_data;
                link.pix_index <= PIX_IDX_W'(px - PX_DUMMY);
                link.pix_last  <= last_px;
            end

            err_overrun <= (err_overrun && !err_clr) ||
                           (new_pix && link.pix_valid && !link.pix_ready);
            err_missed  <= (err_missed && !err_clr) || missed;
        end
    end

endmodule

// File: tb/tb_ccd_line_sequencer.sv
// Scoreboard bench for ccd_line_sequencer with a small-line configuration and a 3-cycle ADC model.
module tb_ccd_line_sequencer;
    import ccd_line_sequencer_pkg::*;

    localparam int INT_W = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run = 1'b0;
    logic err_clr = 1'b0;
    logic [INT_W-1:0] int_cycles = 10;
    logic busy, line_done, ccd_p1, ccd_p2, ccd_sh, ccd_rs, ccd_cp, err_overrun, err_missed;

    ccd_line_sequencer_if link ();

    ccd_line_sequencer #(
        .PIX_COUNT(4), .DUMMY_PIX(2), .PIX_DIV(16), .RS_W(2), .CP_W(2),
        .SAMPLE_PT(6), .SH_W(8), .SH_GAP(4), .INT_W(INT_W)
    ) dut (
        .clk_100M(clk), .rst(rst), .run(run), .int_cycles(int_cycles), .err_clr(err_clr),
        .busy(busy), .line_done(line_done), .ccd_p1(ccd_p1), .ccd_p2(ccd_p2),
        .ccd_sh(ccd_sh), .ccd_rs(ccd_rs), .ccd_cp(ccd_cp),
        .err_overrun(err_overrun), .err_missed(err_missed), .link(link)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [15:0] d;
        logic [11:0] i;
        logic        l;
    } pix_t;
    pix_t exp_q[$];

    task automatic push(input int d, input int i, input bit l);
        pix_t e;
        e.d = d[15:0];
        e.i = i[11:0];
        e.l = l;
        exp_q.push_back(e);
    endtask

    task automatic push_line();
        push(2, 0, 0); push(3, 1, 0); push(4, 2, 0); push(5, 3, 1);
    endtask

    // event recorder (cycle stamps)
    int sh_rise[$], sh_fall[$], rs_rise[$], starts[$], dones[$];
    task automatic clr_rec();
        sh_rise.delete(); sh_fall.delete(); rs_rise.delete(); starts.delete(); dones.delete();
    endtask

    initial begin : recorder
        logic sh_prev, rs_prev;
        sh_prev = 1'b0;
        rs_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (ccd_sh && !sh_prev) sh_rise.push_back(cyc);
            if (!ccd_sh && sh_prev) sh_fall.push_back(cyc);
            if (ccd_rs && !rs_prev) rs_rise.push_back(cyc);
            if (link.adc_start) starts.push_back(cyc);
            if (line_done) dones.push_back(cyc);
            sh_prev = ccd_sh;
            rs_prev = ccd_rs;
        end
    end

    // ADC model: answers 3 cycles after adc_start with data = pixel number in the line
    int withhold_px = -1;
    initial begin : adc_model
        int nstart;
        int k;
        nstart = 0;
        forever begin
            @(negedge clk);
            if (ccd_sh) nstart = 0;
            if (link.adc_start) begin
                k = nstart;
                nstart++;
                if (k != withhold_px) begin
                    @(posedge clk);
                    @(posedge clk);
                    #1 link.adc_done = 1'b1;
                    link.adc_data = k[15:0];
                    @(posedge clk);
                    #1 link.adc_done = 1'b0;
                end
            end
        end
    end

    initial begin : monitor
        pix_t e;
        forever begin
            @(negedge clk);
            if (!rst && link.pix_valid && link.pix_ready) begin
                chk("pix_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("pix_data", link.pix_data, e.d);
                    chk("pix_index", link.pix_index, e.i);
                    chk("pix_last", link.pix_last, e.l);
                end
            end
        end
    end

    task automatic wait_idle(input string name, input int budget);
        int i = 0;
        while (busy && i < budget) begin @(negedge clk); i++; end
        chk(name, busy, 0);
    endtask

    task automatic wait_rises(input string name, input int n, input int budget);
        int i = 0;
        while (sh_rise.size() < n && i < budget) begin @(negedge clk); i++; end
        chk(name, sh_rise.size(), n);
    endtask

    task automatic one_line(input string name);
        @(negedge clk); run = 1'b1;
        @(negedge clk); run = 1'b0;
        wait_idle(name, 300);
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic spurious_done();
        @(posedge clk); #1 link.adc_done = 1'b1; link.adc_data = 16'hBEEF;
        @(posedge clk); #1 link.adc_done = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1);
    end

    initial begin : main
        link.adc_done = 1'b0;
        link.adc_data = '0;
        link.pix_ready = 1'b1;
        repeat (3) @(negedge clk);

        chk("reset_ctrl", {busy, line_done, ccd_p1, ccd_p2, ccd_sh, ccd_rs, ccd_cp, link.adc_start,
                           link.pix_valid, link.pix_last, err_overrun, err_missed}, 0);
        chk("reset_pix", {link.pix_data, link.pix_index}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // single line timing and data
        clr_rec();
        push_line();
        one_line("t1_line_end");
        chk("t1_sh_rises", sh_rise.size(), 1);
        if (sh_rise.size() == 1 && sh_fall.size() == 1)
            chk("t1_sh_width", sh_fall[0] - sh_rise[0], 8);
        if (sh_fall.size() == 1 && rs_rise.size() > 0)
            chk("t1_guard", rs_rise[0] - sh_fall[0], 4);
        chk("t1_adc_starts", starts.size(), 6);
        for (int i = 1; i < starts.size(); i++)
            chk("t1_adc_spacing", starts[i] - starts[i-1], 16);
        if (starts.size() > 0 && rs_rise.size() > 0)
            chk("t1_sample_pt", starts[0] - rs_rise[0], 6);
        chk("t1_line_done_cnt", dones.size(), 1);
        if (dones.size() == 1 && rs_rise.size() > 0)
            chk("t1_readout_len", dones[0] - rs_rise[0] + 1, 96);
        chk("t1_pixels_left", exp_q.size(), 0);
        chk("t1_flags", {err_overrun, err_missed}, 0);

        // continuous run: line period follows int_cycles
        clr_rec();
        int_cycles = 300;
        for (int l = 0; l < 3; l++) push_line();
        @(negedge clk); run = 1'b1;
        wait_rises("t2_rises_300", 3, 1500);
        run = 1'b0;
        wait_idle("t2_end_300", 400);
        repeat (4) @(negedge clk);
        if (sh_rise.size() == 3) begin
            chk("t2_period_300_a", sh_rise[1] - sh_rise[0], 300);
            chk("t2_period_300_b", sh_rise[2] - sh_rise[1], 300);
        end
        chk("t2_pixels_300", exp_q.size(), 0);

        clr_rec();
        int_cycles = 10;
        for (int l = 0; l < 3; l++) push_line();
        @(negedge clk); run = 1'b1;
        wait_rises("t2_rises_short", 3, 600);
        run = 1'b0;
        wait_idle("t2_end_short", 400);
        repeat (4) @(negedge clk);
        if (sh_rise.size() == 3) begin
            chk("t2_period_short_a", sh_rise[1] - sh_rise[0], 8 + 4 + 96 + 1);
            chk("t2_period_short_b", sh_rise[2] - sh_rise[1], 8 + 4 + 96 + 1);
        end
        chk("t2_pixels_short", exp_q.size(), 0);

        // missed conversion on px 3 (active index 1)
        withhold_px = 3;
        push(2, 0, 0); push(4, 2, 0); push(5, 3, 1);
        one_line("t3_line_end");
        withhold_px = -1;
        chk("t3_err_missed", err_missed, 1);
        chk("t3_no_overrun", err_overrun, 0);
        chk("t3_pixels_left", exp_q.size(), 0);
        pulse_clr();
        chk("t3_missed_cleared", err_missed, 0);

        // downstream stalled for the whole line
        @(posedge clk); #1 link.pix_ready = 1'b0;
        push(2, 0, 0);
        one_line("t4_line_end");
        chk("t4_err_overrun", err_overrun, 1);
        chk("t4_held_valid", link.pix_valid, 1);
        chk("t4_held_data", link.pix_data, 2);
        @(posedge clk); #1 link.pix_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("t4_drained", exp_q.size(), 0);
        chk("t4_valid_low", link.pix_valid, 0);
        pulse_clr();
        chk("t4_overrun_cleared", err_overrun, 0);

        // asynchronous reset mid-readout, then a clean restart
        clr_rec();
        int_cycles = 10;
        @(negedge clk); run = 1'b1;
        begin
            int i = 0;
            while (rs_rise.size() < 2 && i < 200) begin @(negedge clk); i++; end
        end
        chk("t5_in_readout", busy, 1);
        #2 rst = 1'b1;
        #1 chk("t5_async_reset", {busy, line_done, ccd_p1, ccd_p2, ccd_sh, ccd_rs, ccd_cp,
                                  link.adc_start, link.pix_valid, link.pix_last,
                                  err_overrun, err_missed, link.pix_data, link.pix_index}, 0);
        @(negedge clk);
        clr_rec();
        push_line();
        rst = 1'b0;
        wait_rises("t5_restart_sh", 1, 10);
        run = 1'b0;
        wait_idle("t5_line_end", 300);
        repeat (4) @(negedge clk);
        if (sh_rise.size() == 1 && sh_fall.size() == 1)
            chk("t5_sh_width", sh_fall[0] - sh_rise[0], 8);
        chk("t5_adc_starts", starts.size(), 6);
        chk("t5_pixels_left", exp_q.size(), 0);

        // spurious adc_done in IDLE and in WAIT_INT
        spurious_done();
        chk("t6_idle_spurious", {link.pix_valid, err_overrun, err_missed}, 0);

        clr_rec();
        int_cycles = 300;
        push_line();
        @(negedge clk); run = 1'b1;
        begin
            int i = 0;
            while (dones.size() < 1 && i < 300) begin @(negedge clk); i++; end
        end
        chk("t6_line_done", dones.size(), 1);
        repeat (3) @(negedge clk);
        chk("t6_wait_busy", busy, 1);
        chk("t6_wait_clocks", {ccd_p1, ccd_p2, ccd_sh, ccd_rs, ccd_cp}, 5'b10000);
        spurious_done();
        chk("t6_wait_spurious", {link.pix_valid, err_overrun, err_missed}, 0);
        run = 1'b0;
        wait_idle("t6_wait_to_idle", 3);
        chk("t6_pixels_left", exp_q.size(), 0);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ccd_line_sequencer.md
Name: ccd_line_sequencer

Overview:
Sequences one or more CCD line captures. Per line it generates the shift-gate transfer, the per-pixel P1/P2/RS/CP clocking, and one ADC conversion request per pixel. It discards dummy pixels and emits valid image pixels as an indexed stream toward the FT bus packetiser. It sits between the host command logic and the CCD, ADC-reader and FT-bus blocks in the scanner top level.

Parameters:
PIX_COUNT, 2160, active pixels per line
DUMMY_PIX, 32, leading dummy pixels clocked out and discarded
PIX_DIV, 50, clk_100M cycles per pixel period (min 16)
RS_W, 4, RS pulse width in cycles from pixel-period start
CP_W, 4, CP pulse width, starting at cycle RS_W
SAMPLE_PT, 12, pixel-period cycle at which adc_start pulses (RS_W+CP_W < SAMPLE_PT < PIX_DIV-1)
SH_W, 200, SH high cycles
SH_GAP, 100, guard cycles after SH falls, before readout
ADC_W, 16, sample width
INT_W, 24, integration counter width

Ports:
clk_100M  in  1  system clock
rst  in  1  asynchronous active-high reset
run  in  1  level; lines repeat while high
int_cycles  in  INT_W  line period in cycles, latched at each SH_PULSE entry
err_clr  in  1  pulse; clears sticky flags
busy  out  1  high when state is not IDLE
line_done  out  1  one-cycle pulse at end of final pixel period
ccd_p1, ccd_p2, ccd_sh, ccd_rs, ccd_cp  out  1 each  CCD clocks
adc_start  out  1  one-cycle conversion request
adc_done  in  1  conversion complete strobe
adc_data  in  ADC_W  sample, valid with adc_done
pix_valid  out  1  output pixel valid
pix_ready  in  1  downstream accept
pix_data  out  ADC_W  pixel value
pix_index  out  12  active pixel index, 0..PIX_COUNT-1
pix_last  out  1  with pix_valid on index PIX_COUNT-1
err_overrun  out  1  sticky: new pixel arrived while previous not accepted
err_missed  out  1  sticky: adc_done absent by end of pixel period

Behaviour:
- Reset (async, any state): state IDLE; all outputs 0; counters 0; no conversion outstanding.
- IDLE: all CCD clocks low. When run=1, go to SH_PULSE on the next cycle.
- SH_PULSE: latch int_cycles; clear line timer; sh=1, p1=1, p2=0 for SH_W cycles; then sh=0, p1=1 for SH_GAP cycles; then go to READOUT.
- READOUT: pixel counter pc 0..PIX_DIV-1, pixel index px 0..DUMMY_PIX+PIX_COUNT-1.
  - p1 = (pc < PIX_DIV/2); p2 = !p1.
  - rs = (pc < RS_W); cp = (RS_W <= pc < RS_W+CP_W).
  - adc_start = (pc == SAMPLE_PT); this marks a conversion outstanding.
- adc_done while a conversion is outstanding: capture adc_data and clear outstanding.
  - If px >= DUMMY_PIX: present pixel with pix_index = px-DUMMY_PIX.
  - If px < DUMMY_PIX: discard.
- adc_done while no conversion is outstanding: ignored.
- Conversion still outstanding at pc == PIX_DIV-1: set err_missed; abandon the conversion; emit nothing for that pixel.
- Output register is single-entry; pixel held until pix_valid && pix_ready. A new pixel arriving while pix_valid=1 and pix_ready=0: set err_overrun, keep the old pixel, drop the new one. If pix_ready=1 in that cycle, the old pixel transfers and the new one loads with no error.
- End of final pixel period (px last, pc == PIX_DIV-1): line_done=1 for one cycle.
  - run=0: go to IDLE.
  - Otherwise: go to WAIT_INT.
- WAIT_INT: p1=1, others low.
  - When line timer >= latched int_cycles: go to SH_PULSE.
  - If int_cycles is less than the line length, the transition is immediate (one cycle in WAIT_INT).
  - run=0 in WAIT_INT: go to IDLE.
- Line timer saturates at all-ones; it does not wrap.
- run falling during SH_PULSE/READOUT: the current line completes, then IDLE. run is sampled only at end of READOUT and in WAIT_INT.
- err_clr clears both flags. An error event in the same cycle as err_clr wins: the flag stays set.
- Pending output pixel survives the IDLE transition until accepted.

Decomposition:
- film_scanner_pkg:
  - ccd_seq_state_t enum {IDLE, SH_PULSE, READOUT, WAIT_INT}
  - default timing constants
  - ADC_W
- One sub-module, ccd_pixel_timer: pc counter plus combinational p1/p2/rs/cp/adc_start decode. Inputs are enable and restart; it also outputs period_end.

Test Plan:
- Params PIX_COUNT=4, DUMMY_PIX=2, PIX_DIV=16, RS_W=2, CP_W=2, SAMPLE_PT=6, SH_W=8, SH_GAP=4. ADC model answers 3 cycles after adc_start with data=px. Single line (run pulsed high for one line):
  - sh high exactly 8 cycles, then 4 guard cycles;
  - 6 adc_start pulses, 16 cycles apart;
  - 4 pixels out with data 2,3,4,5 and index 0..3; pix_last only on index 3;
  - line_done pulses once, 96 cycles after READOUT entry.
- run held high, int_cycles=300: consecutive SH rising edges exactly 300 cycles apart. With int_cycles=10, the period equals 8+4+96+1 cycles.
- ADC model withholds adc_done for px=3: err_missed=1; pixel index 1 missing from the stream; other pixels correct. err_clr returns it to 0.
- pix_ready=0 for the whole line: first pixel (data 2) held; err_overrun=1. Raising pix_ready then delivers data 2 only.
- rst asserted mid-READOUT: all outputs 0 asynchronously. After release with run=1, the next line starts cleanly with SH_PULSE.
- Spurious adc_done in IDLE and in WAIT_INT: no pix_valid, no flags.
